ddr_rx_word_aligner: RTL and testbench

- Downstream consumer of the I_DDR input primitive.
- Takes the 2-bit per-clock DDR sample pair and assembles a serial stream into WORD_WIDTH-bit parallel words.
- Word alignment is found with a training-pattern hunt (bit-slip over a history window).
- Emits aligned words with a one-cycle valid strobe to fabric logic, all in the CLK domain.

---
 rtl/ddr_rx_pkg.sv | 20 ++
 rtl/ddr_rx_word_aligner_if.sv | 26 ++
 rtl/ddr_rx_align_fsm.sv | 102 ++++++++++
 rtl/ddr_rx_word_aligner.sv | 88 ++++++++
 tb/tb_ddr_rx_word_aligner.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ddr_rx_pkg.sv
// Shared types and defaults for the DDR receive word aligner.
// Holds the alignment state encoding, default parameters and the offset-width helper.
package ddr_rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } align_state_e;

    localparam int          DEF_WORD_WIDTH    = 8;
    localparam logic [31:0] DEF_ALIGN_PATTERN = 32'h0000_00B5;
    localparam int          DEF_LOCK_COUNT    = 4;

    // Width of a counter/offset spanning 0..w-1; never narrower than one bit.
    function automatic int ofs_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/ddr_rx_word_aligner_if.sv
// Sample-pair input and aligned-word output bundle of the DDR receive word aligner.
// The aligner takes the slave side; the sample source and word consumer take the master side.
interface ddr_rx_word_aligner_if
    import ddr_rx_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
);
    logic [1:0]                         ddr_q;
    logic                               en;
    logic                               resync;
    logic [WORD_WIDTH-1:0]              word;
    logic                               word_valid;
    logic                               locked;
    logic                               align_err;
    logic [ofs_width(WORD_WIDTH)-1:0]   slip_ofs;

    modport slave (
        input  ddr_q, en, resync,
        output word, word_valid, locked, align_err, slip_ofs
    );

    modport master (
        output ddr_q, en, resync,
        input  word, word_valid, locked, align_err, slip_ofs
    );
endinterface

// File: rtl/ddr_rx_align_fsm.sv
// Hunt/confirm/lock controller, evaluated once per extracted word.
// Requests a one-bit slip on each rejected word and flags a full revolution without a match.
module ddr_rx_align_fsm
    import ddr_rx_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic word_strobe,
    input  logic match,
    input  logic resync,
    output logic slip,
    output logic locked,
    output logic align_err
);
    localparam logic [1:0] S_HUNT    = HUNT;
    localparam logic [1:0] S_CONFIRM = CONFIRM;
    localparam logic [1:0] S_LOCKED  = LOCKED;

    localparam int             SW                = ofs_width(WORD_WIDTH);
    localparam logic [SW-1:0]  SLIP_LAST         = SW'(WORD_WIDTH - 1);
    localparam logic [3:0]     MATCH_LAST        = 4'(LOCK_COUNT - 1);
    localparam logic [1:0]     FIRST_MATCH_STATE = (LOCK_COUNT == 1) ? S_LOCKED : S_CONFIRM;

    logic [1:0]    state_reg,     state_next;
    logic [3:0]    match_cnt_reg, match_cnt_next;
    logic [SW-1:0] slip_cnt_reg,  slip_cnt_next;
    logic          align_err_reg, align_err_next;

    always_comb begin
        state_next     = state_reg;
        match_cnt_next = match_cnt_reg;
        slip_cnt_next  = slip_cnt_reg;
        align_err_next = 1'b0;
        slip           = 1'b0;
        if (resync) begin
            // Re-hunt from the current offset; a coincident word is discarded.
            state_next     = S_HUNT;
            match_cnt_next = '0;
            slip_cnt_next  = '0;
        end else if (word_strobe) begin
            if (match) begin
                slip_cnt_next = '0;
            end
            case (state_reg)
                S_HUNT: begin
                    if (match) begin
                        match_cnt_next = 4'd1;
                        state_next     = FIRST_MATCH_STATE;
                    end else begin
                        slip = 1'b1;
                    end
                end
                S_CONFIRM: begin
                    if (match) begin
                        match_cnt_next = match_cnt_reg + 4'd1;
                        if (match_cnt_reg == MATCH_LAST) begin
                            state_next = S_LOCKED;
                        end
                    end else begin
                        slip           = 1'b1;
                        match_cnt_next = '0;
                        state_next     = S_HUNT;
                    end
                end
                S_LOCKED: begin
                end
                default: begin
                    state_next = S_HUNT;
                end
            endcase
            if (slip) begin
                if (slip_cnt_reg == SLIP_LAST) begin
                    align_err_next = 1'b1;
                    slip_cnt_next  = '0;
                end else begin
                    slip_cnt_next = slip_cnt_reg + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_HUNT;
            match_cnt_reg <= '0;
            slip_cnt_reg  <= '0;
            align_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            match_cnt_reg <= match_cnt_next;
            slip_cnt_reg  <= slip_cnt_next;
            align_err_reg <= align_err_next;
        end
    end

    assign locked    = (state_reg == S_LOCKED);
    assign align_err = align_err_reg;

endmodule

// File: rtl/ddr_rx_word_aligner.sv
// Assembles I_DDR sample pairs into WORD_WIDTH-bit words and aligns them to a training pattern.
// A sliding window over the bit history is selected by the slip offset chosen by the align FSM.
module ddr_rx_word_aligner
    import ddr_rx_pkg::*;
#(
    parameter int                    WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] ALIGN_PATTERN = WORD_WIDTH'(DEF_ALIGN_PATTERN),
    parameter int                    LOCK_COUNT    = DEF_LOCK_COUNT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ddr_rx_word_aligner_if.slave  bus
);
    localparam int HW = 2 * WORD_WIDTH;
    localparam int PW = ofs_width(WORD_WIDTH / 2);
    localparam int OW = ofs_width(WORD_WIDTH);

    localparam logic [PW-1:0] PHASE_LAST = PW'(WORD_WIDTH / 2 - 1);
    localparam logic [OW-1:0] OFS_LAST   = OW'(WORD_WIDTH - 1);

    logic [HW-1:0]         history_reg, history_next;
    logic [PW-1:0]         phase_reg;
    logic [OW-1:0]         slip_ofs_reg, slip_ofs_next;
    logic [WORD_WIDTH-1:0] word_reg;
    logic                  strobe_reg;
    logic                  boundary;
    logic                  slip;
    logic                  locked;
    logic                  align_err;
    logic                  match;
    logic [WORD_WIDTH-1:0] window_cand [WORD_WIDTH];

    // Newest bit sits at history[0]; the falling-edge sample is the later of the pair.
    assign history_next = bus.en ? {history_reg[HW-3:0], bus.ddr_q[0], bus.ddr_q[1]}
                                 : history_reg;
    assign boundary     = bus.en && (phase_reg == PHASE_LAST);

    // A slip decided this cycle already applies to a word extracted on the same edge.
    assign slip_ofs_next = !slip                   ? slip_ofs_reg :
                           (slip_ofs_reg == OFS_LAST) ? '0 : slip_ofs_reg + OW'(1);

    for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_window
        assign window_cand[gi] = history_next[gi +: WORD_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history_reg  <= '0;
            phase_reg    <= '0;
            slip_ofs_reg <= '0;
            word_reg     <= '0;
            strobe_reg   <= 1'b0;
        end else begin
            history_reg  <= history_next;
            slip_ofs_reg <= slip_ofs_next;
            strobe_reg   <= boundary;
            if (bus.en) begin
                phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + PW'(1);
            end
            if (boundary) begin
                word_reg <= window_cand[slip_ofs_next];
            end
        end
    end

    assign match = (word_reg == ALIGN_PATTERN);

    ddr_rx_align_fsm #(
        .WORD_WIDTH (WORD_WIDTH),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_align_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .word_strobe (strobe_reg),
        .match       (match),
        .resync      (bus.resync),
        .slip        (slip),
        .locked      (locked),
        .align_err   (align_err)
    );

    assign bus.word       = word_reg;
    assign bus.word_valid = strobe_reg && locked && !bus.resync;
    assign bus.locked     = locked;
    assign bus.align_err  = align_err;
    assign bus.slip_ofs   = slip_ofs_reg;

endmodule

// File: tb/tb_ddr_rx_word_aligner.sv
// Directed bench for the DDR receive word aligner (WORD_WIDTH=8, pattern 8'hB5, LOCK_COUNT=4).
// Streams bits MSB-first as sample pairs and checks lock, slips, strobes and reset behaviour.
module tb_ddr_rx_word_aligner;
    import ddr_rx_pkg::*;

    localparam logic [7:0] PAT = 8'hB5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ddr_rx_word_aligner_if #(.WORD_WIDTH(8)) bus();

    ddr_rx_word_aligner #(
        .WORD_WIDTH    (8),
        .ALIGN_PATTERN (PAT),
        .LOCK_COUNT    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       bits_q [$];
    int         cyc = 0;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    int         last_valid_cyc = -1;
    int         last_gap = 0;
    logic [7:0] s_word;
    logic       s_valid, s_locked, s_err;
    logic [2:0] s_ofs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%0h", tag, got);
        end
    endtask

    // Drive one cycle of inputs, sample mid-cycle on the falling edge, return just past the next rise.
    task automatic step(input logic [1:0] q, input logic e, input logic rs);
        bus.ddr_q  = q;
        bus.en     = e;
        bus.resync = rs;
        @(negedge clk);
        cyc++;
        s_word   = bus.word;
        s_valid  = bus.word_valid;
        s_locked = bus.locked;
        s_err    = bus.align_err;
        s_ofs    = bus.slip_ofs;
        if (s_valid) begin
            valid_cnt++;
            if (last_valid_cyc >= 0) last_gap = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
        end
        if (s_err) err_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) bits_q.push_back(w[i]);
    endtask

    task automatic pop_pair(output logic [1:0] q);
        logic b0, b1;
        b0 = (bits_q.size() > 0) ? bits_q.pop_front() : 1'b0;
        b1 = (bits_q.size() > 0) ? bits_q.pop_front() : 1'b0;
        q = {b1, b0};
    endtask

    task automatic feed(input int n);
        logic [1:0] q;
        for (int i = 0; i < n; i++) begin
            pop_pair(q);
            step(q, 1'b1, 1'b0);
        end
    endtask

    // Each valid pair is followed by an ignored cycle carrying junk on DDR_Q.
    task automatic feed_toggle(input int n);
        logic [1:0] q;
        for (int i = 0; i < n; i++) begin
            pop_pair(q);
            step(q, 1'b1, 1'b0);
            step(2'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        bus.ddr_q  = 2'b00;
        bus.en     = 1'b0;
        bus.resync = 1'b0;
        bits_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0; valid_cnt = 0; err_cnt = 0; last_valid_cyc = -1; last_gap = 0;
    endtask

    initial begin
        logic [1:0] q;

        // Reset state
        bus.ddr_q = 2'b00; bus.en = 1'b0; bus.resync = 1'b0;
        #12;
        check_eq("rst_word",   32'(bus.word), 32'h0);
        check_eq("rst_valid",  32'(bus.word_valid), 32'h0);
        check_eq("rst_locked", 32'(bus.locked), 32'h0);
        check_eq("rst_err",    32'(bus.align_err), 32'h0);
        check_eq("rst_ofs",    32'(bus.slip_ofs), 32'h0);

        // Aligned B5 stream: lock after the 4th strobe, then a valid word every 4 cycles
        do_reset();
        for (int i = 0; i < 16; i++) push_word(PAT);
        feed(16);
        check_eq("t1_unlocked_3_strobes", 32'(s_locked), 32'h0);
        feed(4);
        check_eq("t1_locked_after_4", 32'(s_locked), 32'h1);
        check_eq("t1_no_valid_before_lock", 32'(valid_cnt), 32'h0);
        feed(16);
        check_eq("t1_valid_count", 32'(valid_cnt), 32'd4);
        check_eq("t1_valid_gap", 32'(last_gap), 32'd4);
        check_eq("t1_word", 32'(s_word), 32'(PAT));
        check_eq("t1_ofs", 32'(s_ofs), 32'h0);
        check_eq("t1_no_err", 32'(err_cnt), 32'h0);

        // Same lock with EN toggling: a valid word every 8 cycles, no slips
        valid_cnt = 0;
        feed_toggle(16);
        check_eq("t4_valid_count", 32'(valid_cnt), 32'd5);
        check_eq("t4_valid_gap", 32'(last_gap), 32'd8);
        check_eq("t4_word", 32'(s_word), 32'(PAT));
        check_eq("t4_ofs", 32'(s_ofs), 32'h0);
        check_eq("t4_locked", 32'(s_locked), 32'h1);

        // Pattern ends 3 bits before each boundary (5 leading bits): 3 slips then lock
        do_reset();
        for (int i = 0; i < 5; i++) bits_q.push_back(1'b0);
        for (int i = 0; i < 16; i++) push_word(PAT);
        feed(16);
        check_eq("t2_ofs_after_slips", 32'(s_ofs), 32'd3);
        check_eq("t2_unlocked", 32'(s_locked), 32'h0);
        feed(14);
        check_eq("t2_locked", 32'(s_locked), 32'h1);
        check_eq("t2_ofs_locked", 32'(s_ofs), 32'd3);
        valid_cnt = 0;
        feed(4);
        check_eq("t2_valid_count", 32'(valid_cnt), 32'd1);
        check_eq("t2_word", 32'(s_word), 32'(PAT));
        check_eq("t2_no_err", 32'(err_cnt), 32'h0);

        // RESYNC on a strobe cycle: suppressed valid, unlock, relock at same offset
        feed(2);
        valid_cnt = 0;
        pop_pair(q);
        step(q, 1'b1, 1'b1);
        check_eq("t5_valid_suppressed", 32'(s_valid), 32'h0);
        check_eq("t5_valid_count", 32'(valid_cnt), 32'h0);
        feed(1);
        check_eq("t5_unlocked", 32'(s_locked), 32'h0);
        feed(15);
        check_eq("t5_still_confirming", 32'(s_locked), 32'h0);
        feed(1);
        check_eq("t5_relocked", 32'(s_locked), 32'h1);
        check_eq("t5_ofs_kept", 32'(s_ofs), 32'd3);

        // Asynchronous reset mid-word while locked
        feed(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_word",   32'(bus.word), 32'h0);
        check_eq("t6_async_locked", 32'(bus.locked), 32'h0);
        check_eq("t6_async_ofs",    32'(bus.slip_ofs), 32'h0);
        check_eq("t6_async_valid",  32'(bus.word_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bits_q.delete();
        push_word(PAT);
        push_word(PAT);
        feed(4);
        check_eq("t6_no_word_yet", 32'(s_word), 32'h0);
        feed(1);
        check_eq("t6_first_word", 32'(s_word), 32'(PAT));

        // All-zero stream: ALIGN_ERR every 8 strobes, offset wraps, never valid
        do_reset();
        feed(30);
        check_eq("t3_ofs_7", 32'(s_ofs), 32'd7);
        check_eq("t3_no_err_yet", 32'(err_cnt), 32'h0);
        feed(4);
        check_eq("t3_ofs_wrap", 32'(s_ofs), 32'h0);
        check_eq("t3_err_once", 32'(err_cnt), 32'd1);
        feed(32);
        check_eq("t3_err_twice", 32'(err_cnt), 32'd2);
        check_eq("t3_never_valid", 32'(valid_cnt), 32'h0);
        check_eq("t3_unlocked", 32'(s_locked), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
